// File: rtl/ofm_collector.sv
// rtl/ofm_collector.sv - per-column output-feature-map FIFOs merged round-robin into one write stream
// An empty stage takes a word straight from the sum input so a lone push reaches wr_valid a cycle later.
module ofm_collector #(
    parameter int COL        = 4,
    parameter int OFM_WIDTH  = 32,
    parameter int TILE_LEN   = 8,
    parameter int FIFO_DEPTH = 4,
    localparam int CW        = (COL > 1) ? $clog2(COL) : 1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     start,
    input  logic [COL-1:0]           sum_valid,
    input  logic [COL*OFM_WIDTH-1:0] sum,
    output logic                     wr_valid,
    input  logic                     wr_ready,
    output logic [OFM_WIDTH-1:0]     wr_data,
    output logic [CW-1:0]            wr_col,
    output logic                     wr_last,
    output logic                     overflow,
    output logic                     idle
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = (TILE_LEN > 1) ? $clog2(TILE_LEN) : 1;

    typedef enum logic {EMPTY, HOLD} state_t;

    state_t                 state_q, state_d;
    logic [OFM_WIDTH-1:0]   data_q, data_d;
    logic [CW-1:0]          col_q, col_d;
    logic [CW-1:0]          last_grant_q, last_grant_d;
    logic                   overflow_q, overflow_d;
    logic [AW:0]            wptr_q [COL];
    logic [AW:0]            wptr_d [COL];
    logic [AW:0]            rptr_q [COL];
    logic [AW:0]            rptr_d [COL];
    logic [TW-1:0]          cnt_q [COL];
    logic [TW-1:0]          cnt_d [COL];
    logic [OFM_WIDTH-1:0]   mem_q [COL][FIFO_DEPTH];
    logic [OFM_WIDTH-1:0]   mem_d [COL][FIFO_DEPTH];

    logic [OFM_WIDTH-1:0]   col_sum [COL];
    logic [OFM_WIDTH-1:0]   head [COL];
    logic [COL-1:0]         fifo_empty, fifo_full, in_valid, avail;
    logic [COL-1:0]         pop, push, drop, take_in;
    logic                   accept, load, grant_found;
    logic [CW-1:0]          grant, idx;

    always_comb begin
        for (int c = 0; c < COL; c++) begin
            col_sum[c]    = sum[c*OFM_WIDTH +: OFM_WIDTH];
            head[c]       = mem_q[c][rptr_q[c][AW-1:0]];
            fifo_empty[c] = (wptr_q[c] == rptr_q[c]);
            fifo_full[c]  = (wptr_q[c][AW] != rptr_q[c][AW]) &&
                            (wptr_q[c][AW-1:0] == rptr_q[c][AW-1:0]);
            in_valid[c]   = sum_valid[c] && !start;
            // An incoming word counts as available so it can bypass an empty FIFO.
            avail[c]      = !fifo_empty[c] || in_valid[c];
        end
    end

    always_comb begin
        grant_found = 1'b0;
        grant       = '0;
        idx         = '0;
        for (int i = 0; i < COL; i++) begin
            idx = CW'((int'(last_grant_q) + 1 + i) % COL);
            if (!grant_found && avail[idx]) begin
                grant_found = 1'b1;
                grant       = idx;
            end
        end
    end

    always_comb begin
        accept       = (state_q == HOLD) && wr_ready;
        load         = !start && ((state_q == EMPTY) || accept);
        state_d      = state_q;
        data_d       = data_q;
        col_d        = col_q;
        last_grant_d = last_grant_q;
        if (start) begin
            state_d      = EMPTY;
            data_d       = '0;
            col_d        = '0;
            last_grant_d = CW'(COL - 1);
        end else if (load) begin
            if (grant_found) begin
                state_d      = HOLD;
                col_d        = grant;
                last_grant_d = grant;
                data_d       = fifo_empty[grant] ? col_sum[grant] : head[grant];
            end else begin
                state_d = EMPTY;
            end
        end
    end

    always_comb begin
        mem_d      = mem_q;
        overflow_d = overflow_q;
        for (int c = 0; c < COL; c++) begin
            pop[c]     = load && grant_found && (grant == CW'(c)) && !fifo_empty[c];
            take_in[c] = load && grant_found && (grant == CW'(c)) && fifo_empty[c];
            // A full FIFO popped this cycle has room for the incoming word.
            push[c]    = in_valid[c] && !take_in[c] && (!fifo_full[c] || pop[c]);
            drop[c]    = in_valid[c] && !take_in[c] && fifo_full[c] && !pop[c];
            wptr_d[c]  = wptr_q[c] + {{AW{1'b0}}, push[c]};
            rptr_d[c]  = rptr_q[c] + {{AW{1'b0}}, pop[c]};
            cnt_d[c]   = cnt_q[c];
            if (push[c]) begin
                mem_d[c][wptr_q[c][AW-1:0]] = col_sum[c];
            end
            if (accept && (col_q == CW'(c))) begin
                cnt_d[c] = (cnt_q[c] == TW'(TILE_LEN - 1)) ? '0 : cnt_q[c] + TW'(1);
            end
            if (start) begin
                wptr_d[c] = '0;
                rptr_d[c] = '0;
                cnt_d[c]  = '0;
            end
        end
        if (|drop) begin
            overflow_d = 1'b1;
        end
        if (start) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= EMPTY;
            data_q       <= '0;
            col_q        <= '0;
            last_grant_q <= CW'(COL - 1);
            overflow_q   <= 1'b0;
            for (int c = 0; c < COL; c++) begin
                wptr_q[c] <= '0;
                rptr_q[c] <= '0;
                cnt_q[c]  <= '0;
                for (int d = 0; d < FIFO_DEPTH; d++) begin
                    mem_q[c][d] <= '0;
                end
            end
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            col_q        <= col_d;
            last_grant_q <= last_grant_d;
            overflow_q   <= overflow_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            cnt_q        <= cnt_d;
            mem_q        <= mem_d;
        end
    end

    assign wr_valid = (state_q == HOLD);
    assign wr_data  = data_q;
    assign wr_col   = col_q;
    assign wr_last  = (state_q == HOLD) && (cnt_q[col_q] == TW'(TILE_LEN - 1));
    assign overflow = overflow_q;
    assign idle     = (state_q == EMPTY) && (&fifo_empty);

endmodule

// File: tb/tb_ofm_collector.sv
// tb/tb_ofm_collector.sv - directed bench for ofm_collector with immediate-assertion checks
module tb_ofm_collector;

    localparam int COL = 4;
    localparam int W   = 32;

    logic             clk = 1'b0;
    logic             rstn;
    logic             start;
    logic [COL-1:0]   sum_valid;
    logic [COL*W-1:0] sum;
    logic             wr_valid;
    logic             wr_ready;
    logic [W-1:0]     wr_data;
    logic [1:0]       wr_col;
    logic             wr_last;
    logic             overflow;
    logic             idle;

    int n_checks = 0;
    int n_pass   = 0;

    ofm_collector #(.COL(COL), .OFM_WIDTH(W), .TILE_LEN(8), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rstn(rstn), .start(start), .sum_valid(sum_valid), .sum(sum),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_col(wr_col),
        .wr_last(wr_last), .overflow(overflow), .idle(idle)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int c, input logic [W-1:0] v);
        sum_valid = '0;
        sum       = '0;
        sum_valid[c] = 1'b1;
        sum[c*W +: W] = v;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; sum_valid = '0; sum = '0; wr_ready = 1'b1;
        tick(); tick();
        check("rst_valid", wr_valid, 0);
        check("rst_data", wr_data, 0);
        check("rst_col", wr_col, 0);
        check("rst_last", wr_last, 0);
        check("rst_ovf", overflow, 0);
        check("rst_idle", idle, 1);
        rstn = 1'b1;

        // Single push of -5 to column 0.
        put(0, 32'hFFFF_FFFB);
        tick();
        sum_valid = '0;
        check("single_valid", wr_valid, 1);
        check("single_data", wr_data, 32'hFFFF_FFFB);
        check("single_col", wr_col, 0);
        check("single_last", wr_last, 0);
        tick();
        check("single_idle_valid", wr_valid, 0);
        check("single_idle", idle, 1);

        // All-column burst from a freshly reset grant pointer.
        pulse_start();
        sum_valid = 4'b1111;
        sum = {32'd13, 32'd12, 32'd11, 32'd10};
        tick();
        sum_valid = '0;
        for (int k = 0; k < 4; k++) begin
            check("burst_valid", wr_valid, 1);
            check("burst_col", wr_col, k);
            check("burst_data", wr_data, 10 + k);
            tick();
        end
        check("burst_done", wr_valid, 0);
        check("burst_idle", idle, 1);

        // Backpressure: 6 pushes to column 2, the 6th is dropped.
        pulse_start();
        wr_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            put(2, 100 + k);
            tick();
            if (k == 0) check("bp_first_data", wr_data, 100);
            if (k == 4) check("bp_ovf_after5", overflow, 0);
        end
        sum_valid = '0;
        check("bp_ovf_after6", overflow, 1);
        check("bp_hold_valid", wr_valid, 1);
        check("bp_hold_data", wr_data, 100);
        tick();
        check("bp_hold_data2", wr_data, 100);
        wr_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("bp_drain_valid", wr_valid, 1);
            check("bp_drain_data", wr_data, 100 + k);
            check("bp_drain_col", wr_col, 2);
            tick();
        end
        check("bp_drained", wr_valid, 0);
        check("bp_ovf_sticky", overflow, 1);

        // A full FIFO popped in the same cycle accepts the push without overflow.
        pulse_start();
        wr_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            put(3, 200 + k);
            tick();
        end
        put(3, 205);
        wr_ready = 1'b1;
        tick();
        sum_valid = '0;
        check("popfull_ovf", overflow, 0);
        for (int k = 1; k < 6; k++) begin
            check("popfull_data", wr_data, 200 + k);
            tick();
        end
        check("popfull_done", wr_valid, 0);

        // Line marking: 17 words to column 1.
        pulse_start();
        put(1, 300);
        for (int k = 0; k < 17; k++) begin
            tick();
            if (k < 16) put(1, 301 + k);
            else sum_valid = '0;
            check("line_valid", wr_valid, 1);
            check("line_data", wr_data, 300 + k);
            check("line_last", wr_last, (k == 7 || k == 15) ? 1 : 0);
        end
        tick();
        check("line_done", wr_valid, 0);

        // Start mid-run: advance column 0's counter, queue words, overflow, then start.
        pulse_start();
        for (int k = 0; k < 3; k++) begin
            put(0, 400 + k);
            tick();
        end
        sum_valid = '0;
        tick();
        check("pre_start_idle", idle, 1);
        wr_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            put(0, 410 + k);
            tick();
        end
        check("pre_start_ovf", overflow, 1);
        put(0, 499);
        start = 1'b1;
        tick();
        start = 1'b0;
        sum_valid = '0;
        check("start_valid", wr_valid, 0);
        check("start_idle", idle, 1);
        check("start_ovf", overflow, 0);
        wr_ready = 1'b1;
        put(0, 420);
        for (int k = 0; k < 8; k++) begin
            tick();
            if (k < 7) put(0, 421 + k);
            else sum_valid = '0;
            check("restart_data", wr_data, 420 + k);
            check("restart_last", wr_last, (k == 7) ? 1 : 0);
        end
        tick();
        check("restart_done", wr_valid, 0);

        // Asynchronous reset while holding a word.
        wr_ready = 1'b0;
        put(1, 450);
        tick();
        sum_valid = '0;
        check("hold_valid", wr_valid, 1);
        #2 rstn = 1'b0;
        #1;
        check("async_valid", wr_valid, 0);
        check("async_data", wr_data, 0);
        check("async_idle", idle, 1);
        wr_ready = 1'b1;
        tick();
        rstn = 1'b1;
        put(1, 500);
        tick();
        sum_valid = '0;
        check("post_rst_valid", wr_valid, 1);
        check("post_rst_data", wr_data, 500);
        check("post_rst_col", wr_col, 1);
        tick();
        check("post_rst_done", wr_valid, 0);
        check("post_rst_idle", idle, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ofm_collector.md
OFM_COLLECTOR -- requirements
Module: ofm_collector

Interface
REQ-001 The block SHALL have parameter COL, default 4, giving the number of PE-array output columns.
REQ-002 The block SHALL have parameter OFM_WIDTH, default 32, giving the width of one signed partial sum.
REQ-003 The block SHALL have parameter TILE_LEN, default 8, giving the number of words in one tile line per column.
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 4, giving the per-column FIFO depth; it must be a power of two and at least 2.
REQ-005 clk  input  1  single clock; all logic is on the rising edge.
REQ-006 rstn  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  one-cycle pulse aligned with start_conv; clears the collection state.
REQ-008 sum_valid  input  COL  per-column strobe; bit c qualifies the column-c slice of sum.
REQ-009 sum  input  COL*OFM_WIDTH  packed column sums; column c occupies bits [c*OFM_WIDTH +: OFM_WIDTH].
REQ-010 wr_valid  output  1  the output word is valid.
REQ-011 wr_ready  input  1  the downstream writer accepts the word.
REQ-012 wr_data  output  OFM_WIDTH  output sum word.
REQ-013 wr_col  output  max(1,$clog2(COL))  source column of wr_data.
REQ-014 wr_last  output  1  wr_data is the final word of a tile line for wr_col.
REQ-015 overflow  output  1  sticky flag: a sum was dropped.
REQ-016 idle  output  1  all FIFOs and the output stage are empty.

Function
REQ-017 Each column SHALL have an independent FIFO of FIFO_DEPTH entries, written when sum_valid[c] is 1.
REQ-018 A push to a full FIFO SHALL drop the word and set overflow; a full FIFO that is popped in the same cycle SHALL accept the push without overflow.
REQ-019 The output stage SHALL be a two-state FSM: EMPTY goes to HOLD when any FIFO is non-empty; HOLD goes to EMPTY when wr_valid&&wr_ready and no FIFO is non-empty; otherwise HOLD stays in HOLD.
REQ-020 On acceptance in HOLD, the stage SHALL reload in the same cycle from the next granted FIFO.
REQ-021 The grant SHALL be round-robin: search the columns starting at last_grant+1, wrap modulo COL, and pick the first non-empty FIFO; last_grant resets to COL-1.
REQ-022 While wr_valid=1 and wr_ready=0, wr_data, wr_col and wr_last SHALL hold stable and wr_valid SHALL stay 1.
REQ-023 Latency: a word pushed in cycle N into an empty block SHALL appear on wr_valid/wr_data in cycle N+1.
REQ-024 With wr_ready held at 1, the block SHALL sustain one accepted word per cycle.
REQ-025 Each column SHALL have a line counter, 0..TILE_LEN-1, that increments when that column's word is accepted (wr_valid&&wr_ready).
REQ-026 wr_last SHALL equal 1 when the counter for wr_col equals TILE_LEN-1; the counter then wraps to 0.
REQ-027 Per-column word order SHALL be preserved; no ordering is guaranteed between columns.
REQ-028 sum data SHALL pass through unmodified, with no sign extension or truncation.
REQ-029 idle SHALL equal (FSM==EMPTY) && all FIFOs empty.
REQ-030 When start=1, the next clock edge SHALL synchronously empty all FIFOs, clear the output stage, clear the line counters and overflow, and reset last_grant.
REQ-031 sum_valid asserted in the same cycle as start SHALL be ignored.

Reset
REQ-032 While rstn=0, the outputs SHALL be: wr_valid=0, wr_data=0, wr_col=0, wr_last=0, overflow=0, idle=1.
REQ-033 Reset while the output stage is in HOLD SHALL discard the pending word; wr_valid falls asynchronously.
REQ-034 After rstn rises, the block SHALL accept sum_valid from the first clock edge.

Verification
REQ-035 Single push: sum_valid=4'b0001, sum[0]=-5, wr_ready=1 -> next cycle wr_valid=1, wr_data=-5, wr_col=0, wr_last=0; idle=1 one cycle later.
REQ-036 All-column burst: sum_valid=4'b1111 for 1 cycle, values 10,11,12,13, wr_ready=1 -> four accepted words in consecutive cycles with wr_col 0,1,2,3.
REQ-037 Backpressure/overflow: wr_ready=0 and 6 pushes to column 2 -> wr_valid held with the first word, FIFO full after 5 pushes (4 in FIFO + 1 in stage), 6th push dropped, overflow=1; releasing wr_ready yields 5 words in order.
REQ-038 Line marking: TILE_LEN=8, 17 words to column 1 -> wr_last=1 on the 8th and 16th accepted column-1 words only.
REQ-039 Start mid-run: 3 words queued, wr_ready=0, start pulse -> next cycle wr_valid=0, idle=1, overflow=0; the counters restart so the next 8 words end with wr_last=1.
REQ-040 Async reset in HOLD: rstn=0 mid-cycle -> wr_valid=0 immediately, no word is accepted after release.
